// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO that feeds a UART transmitter one frame at a time
module uart_tx_feeder #(
  parameter int MAXTAM    = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr,
  input  logic [MAXTAM-1:0]    i_wr_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [ADDR_BITS:0]   o_count,
  output logic                 o_overflow,
  output logic                 o_tx_start,
  output logic [MAXTAM-1:0]    o_tx_byte,
  input  logic                 i_tx_done,
  output logic                 o_busy
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;
  localparam logic [ADDR_BITS:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};
  state_t state, state_n;
  logic [MAXTAM-1:0] mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] rd_ptr, wr_ptr;
  logic done_q, done_rise, push, pop;
  assign o_full = o_count == DEPTH;
  assign o_empty = o_count == '0;
  assign o_tx_start = state == LOAD;
  assign o_busy = state != IDLE;
  assign push = i_wr & ~o_full;
  assign pop = (state == IDLE) & ~o_empty;
  assign done_rise = i_tx_done & ~done_q;
  // next state: pop in IDLE, one start cycle in LOAD, wait for a fresh done edge
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (pop ? LOAD : IDLE) :
              state == LOAD ? WAIT :
              (done_rise ? IDLE : WAIT);
  end
  // storage array; stale contents are harmless because count gates reads
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_wr_data;
  end
  // pointers, occupancy, overflow flag, done edge register, state and tx byte
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      o_count    <= '0;
      o_overflow <= 1'b0;
      o_tx_byte  <= '0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      done_q     <= i_tx_done;
      o_overflow <= i_wr & o_full;
      o_count    <= o_count + {{ADDR_BITS{1'b0}}, push} - {{ADDR_BITS{1'b0}}, pop};
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        o_tx_byte <= mem[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;
  logic clk = 1'b0;
  logic rst, wr, done;
  logic [7:0] wr_data;
  logic full, empty, overflow, tx_start, busy;
  logic [4:0] count;
  logic [7:0] tx_byte;
  int checks = 0;
  int errors = 0;
  logic seen;

  uart_tx_feeder #(.MAXTAM(8), .ADDR_BITS(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_wr_data(wr_data),
    .o_full(full), .o_empty(empty), .o_count(count), .o_overflow(overflow),
    .o_tx_start(tx_start), .o_tx_byte(tx_byte), .i_tx_done(done), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drop done then raise it: the raising edge returns the feeder to IDLE
  task automatic finish_frame();
    done = 1'b0;
    tick();
    done = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; wr_data = 8'h00; done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_byte", 32'(tx_byte), 32'h00);
    check("rst_ovf", 32'(overflow), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | tx_start | busy;
    end
    check("idle_quiet", 32'(seen), 32'd0);

    // single byte
    wr = 1'b1; wr_data = 8'hA5;
    tick();
    wr = 1'b0;
    check("one_count", 32'(count), 32'd1);
    check("one_nostart", 32'(tx_start), 32'd0);
    tick();
    check("one_start", 32'(tx_start), 32'd1);
    check("one_byte", 32'(tx_byte), 32'hA5);
    check("one_busy", 32'(busy), 32'd1);
    check("one_popped", 32'(count), 32'd0);
    tick();
    check("one_start_end", 32'(tx_start), 32'd0);
    check("one_wait", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    check("one_hold", 32'(tx_byte), 32'hA5);
    done = 1'b1;
    tick();
    check("one_done_idle", 32'(busy), 32'd0);

    // burst of three while done is still high from the previous frame
    wr = 1'b1; wr_data = 8'h01;
    tick();
    check("burst_c1", 32'(count), 32'd1);
    wr_data = 8'h02;
    tick();
    check("burst_start1", 32'(tx_start), 32'd1);
    check("burst_byte1", 32'(tx_byte), 32'h01);
    check("burst_c2", 32'(count), 32'd1);
    wr_data = 8'h03;
    tick();
    wr = 1'b0;
    check("burst_peak", 32'(count), 32'd2);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | tx_start;
    end
    check("burst_stale_done", 32'(busy), 32'd1);
    check("burst_no_restart", 32'(seen), 32'd0);
    for (int i = 0; i < 2; i++) begin
      finish_frame();
      check("burst_idle", 32'(busy), 32'd0);
      tick();
      check("burst_start", 32'(tx_start), 32'd1);
      check("burst_byte", 32'(tx_byte), 32'(8'h02 + 8'(i)));
    end
    finish_frame();
    check("burst_empty", 32'(empty), 32'd1);
    check("burst_busy", 32'(busy), 32'd0);

    // fill while the frame is stalled, then overflow
    done = 1'b0;
    wr = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_data = 8'(8'h10 + i);
      tick();
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_ovf_quiet", 32'(overflow), 32'd0);
    check("fill_inflight", 32'(tx_byte), 32'h10);
    wr_data = 8'hFF;
    tick();
    wr = 1'b0;
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    tick();
    check("ovf_once", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      finish_frame();
      tick();
      check("drain_start", 32'(tx_start), 32'd1);
      check("drain_byte", 32'(tx_byte), 32'(8'h11 + 8'(i)));
    end
    finish_frame();
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_ff_never", 32'(tx_byte), 32'h20);

    // done held high across reset
    rst = 1'b1; done = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    wr = 1'b1; wr_data = 8'h55;
    tick();
    wr = 1'b0;
    tick();
    check("held_start", 32'(tx_start), 32'd1);
    check("held_byte", 32'(tx_byte), 32'h55);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | tx_start;
    end
    check("held_wait", 32'(busy), 32'd1);
    check("held_no_second", 32'(seen), 32'd0);
    done = 1'b0;
    tick();
    check("held_low_wait", 32'(busy), 32'd1);
    done = 1'b1;
    tick();
    check("held_rise_idle", 32'(busy), 32'd0);

    // reset during WAIT with four entries queued
    done = 1'b0;
    wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(8'h61 + i);
      tick();
    end
    wr = 1'b0;
    check("rw_count", 32'(count), 32'd4);
    check("rw_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_count0", 32'(count), 32'd0);
    check("rw_empty", 32'(empty), 32'd1);
    check("rw_idle", 32'(busy), 32'd0);
    check("rw_start", 32'(tx_start), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | tx_start;
    end
    check("rw_quiet", 32'(seen), 32'd0);
    wr = 1'b1; wr_data = 8'h77;
    tick();
    wr = 1'b0;
    tick();
    check("rw_new_start", 32'(tx_start), 32'd1);
    check("rw_new_byte", 32'(tx_byte), 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
